// File: rtl/vm_pkg.sv
// Shared widths, phase encoding and helpers for the vector-math pipeline
// (element_constructor, dot_product_accumulator and later stages).
package vm_pkg;

  localparam int unsigned ELEMENT_WIDTH_DEF = 3;
  localparam int unsigned VECTOR_LENGTH_DEF = 3;

  typedef enum logic {
    PHASE_A = 1'b0,
    PHASE_B = 1'b1
  } phase_e;

  // Ceiling log2 with clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned elem_w(input int unsigned element_width);
    return element_width * 8;
  endfunction

  function automatic int unsigned prod_w(input int unsigned element_width);
    return 2 * element_width * 8;
  endfunction

  function automatic int unsigned result_w(input int unsigned element_width,
                                           input int unsigned vector_length);
    return prod_w(element_width) + clog2(vector_length);
  endfunction

  localparam int unsigned ELEM_W   = elem_w(ELEMENT_WIDTH_DEF);
  localparam int unsigned PROD_W   = prod_w(ELEMENT_WIDTH_DEF);
  localparam int unsigned RESULT_W = result_w(ELEMENT_WIDTH_DEF, VECTOR_LENGTH_DEF);

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Element stream in, dot-product result out, for dot_product_accumulator.
interface dot_product_accumulator_if
  import vm_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH = 3,
  parameter int unsigned VECTOR_LENGTH = 3
) ();

  localparam int unsigned EW = elem_w(ELEMENT_WIDTH);
  localparam int unsigned RW = result_w(ELEMENT_WIDTH, VECTOR_LENGTH);

  logic [EW-1:0] element;
  logic          element_ready;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          busy;

  modport master (
    output element, element_ready,
    input  result, result_valid, busy
  );

  modport slave (
    input  element, element_ready,
    output result, result_valid, busy
  );

endinterface

// File: rtl/mac_stage.sv
// Accumulates registered products; prod_first restarts the sum, prod_last
// publishes it as a one-cycle result pulse.
module mac_stage #(
  parameter int unsigned PROD_W = 48,
  parameter int unsigned RES_W  = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              prod_first,
  input  logic              prod_last,
  output logic [RES_W-1:0]  result,
  output logic              result_valid
);

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] acc_c;

  always_comb begin
    acc_c = prod_first ? RES_W'(prod) : acc + RES_W'(prod);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= prod_valid & prod_last;
      if (prod_valid) begin
        acc <= acc_c;
        if (prod_last) result <= acc_c;
      end
    end
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Unsigned dot product of interleaved A/B element streams: phase/pair tracking
// and the product register here, accumulation in mac_stage.
module dot_product_accumulator
  import vm_pkg::*;
#(
  parameter int unsigned ELEMENT_WIDTH = 3,
  parameter int unsigned VECTOR_LENGTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  dot_product_accumulator_if.slave  bus
);

  localparam int unsigned EW = elem_w(ELEMENT_WIDTH);
  localparam int unsigned PW = prod_w(ELEMENT_WIDTH);
  localparam int unsigned RW = result_w(ELEMENT_WIDTH, VECTOR_LENGTH);
  localparam int unsigned CW = (VECTOR_LENGTH > 1) ? clog2(VECTOR_LENGTH) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(VECTOR_LENGTH - 1);

  phase_e        phase, phase_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          busy, busy_d;
  logic [EW-1:0] a_reg;
  logic [PW-1:0] prod;
  logic          prod_valid, prod_first, prod_last;
  logic          take_a_c, take_b_c, take_a0_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase      <= PHASE_A;
      cnt        <= '0;
      busy       <= 1'b0;
      a_reg      <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_first <= 1'b0;
      prod_last  <= 1'b0;
    end else begin
      phase      <= phase_d;
      cnt        <= cnt_d;
      busy       <= busy_d;
      prod_valid <= take_b_c;
      if (take_a_c) a_reg <= bus.element;
      if (take_b_c) begin
        prod       <= PW'(a_reg) * PW'(bus.element);
        prod_first <= (cnt == '0);
        prod_last  <= (cnt == LAST_PAIR);
      end
    end
  end

  // Next phase, pair count and busy; a new A0 on the closing edge keeps busy high.
  always_comb begin
    phase_d = phase;
    cnt_d   = cnt;
    busy_d  = busy;
    if (take_a_c) phase_d = PHASE_B;
    if (take_b_c) begin
      phase_d = PHASE_A;
      cnt_d   = (cnt == LAST_PAIR) ? '0 : cnt + CW'(1);
    end
    if (prod_valid && prod_last) busy_d = 1'b0;
    if (take_a0_c) busy_d = 1'b1;
  end

  // Strobe decode.
  always_comb begin
    take_a_c  = 1'b0;
    take_b_c  = 1'b0;
    take_a0_c = 1'b0;
    if (bus.element_ready) begin
      take_a_c  = (phase == PHASE_A);
      take_b_c  = (phase == PHASE_B);
      take_a0_c = (phase == PHASE_A) && (cnt == '0);
    end
  end

  assign bus.busy = busy;

  mac_stage #(
    .PROD_W (PW),
    .RES_W  (RW)
  ) u_mac (
    .clk          (clk),
    .reset        (reset),
    .prod         (prod),
    .prod_valid   (prod_valid),
    .prod_first   (prod_first),
    .prod_last    (prod_last),
    .result       (bus.result),
    .result_valid (bus.result_valid)
  );

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: queue-based model on the default instance
// plus directed literal checks on three small parameterisations.
module tb_dot_product_accumulator;

  localparam int VL = 3;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   n_vec;
  int   n_err;
  int   n_pulses;

  dot_product_accumulator_if #(.ELEMENT_WIDTH(3), .VECTOR_LENGTH(3)) bif ();
  dot_product_accumulator_if #(.ELEMENT_WIDTH(1), .VECTOR_LENGTH(2)) if12 ();
  dot_product_accumulator_if #(.ELEMENT_WIDTH(1), .VECTOR_LENGTH(4)) if14 ();
  dot_product_accumulator_if #(.ELEMENT_WIDTH(3), .VECTOR_LENGTH(1)) if31 ();

  dot_product_accumulator #(.ELEMENT_WIDTH(3), .VECTOR_LENGTH(3)) u_dut (
    .clk(clk), .reset(rst_n), .bus(bif));
  dot_product_accumulator #(.ELEMENT_WIDTH(1), .VECTOR_LENGTH(2)) u_d12 (
    .clk(clk), .reset(rst_n), .bus(if12));
  dot_product_accumulator #(.ELEMENT_WIDTH(1), .VECTOR_LENGTH(4)) u_d14 (
    .clk(clk), .reset(rst_n), .bus(if14));
  dot_product_accumulator #(.ELEMENT_WIDTH(3), .VECTOR_LENGTH(1)) u_d31 (
    .clk(clk), .reset(rst_n), .bus(if31));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect 2*VL elements, emit their dot product one edge after the last B.
  longint unsigned m_elems[$];
  longint unsigned m_pend_val[$];
  int              m_pend_due[$];
  int              edge_k;
  logic            m_valid;
  logic            m_busy;
  logic [63:0]     m_result;
  longint unsigned m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_elems.delete();
      m_pend_val.delete();
      m_pend_due.delete();
      m_valid  = 1'b0;
      m_busy   = 1'b0;
      m_result = 64'd0;
    end else begin
      edge_k++;
      if (bif.element_ready) begin
        m_elems.push_back(64'(bif.element));
        if (m_elems.size() == 2 * VL) begin
          m_sum = 0;
          for (int i = 0; i < VL; i++) m_sum += m_elems[2*i] * m_elems[2*i+1];
          m_pend_val.push_back(m_sum);
          m_pend_due.push_back(edge_k + 1);
          m_elems.delete();
        end
      end
      m_valid = 1'b0;
      if (m_pend_due.size() > 0 && m_pend_due[0] == edge_k) begin
        m_valid  = 1'b1;
        m_result = m_pend_val.pop_front();
        void'(m_pend_due.pop_front());
      end
      m_busy = (m_elems.size() > 0) || (m_pend_due.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("result_valid", 64'(bif.result_valid), 64'(m_valid));
      check("result", 64'(bif.result), m_result);
      check("busy", 64'(bif.busy), 64'(m_busy));
      if (bif.result_valid) n_pulses++;
    end
  end

  int s12 [4] = '{2, 5, 3, 7};
  int s31 [4] = '{2, 3, 4, 5};
  int v31 [6] = '{0, 0, 1, 0, 1, 0};
  int r31 [6] = '{0, 0, 6, 6, 20, 20};
  int b31 [6] = '{1, 1, 1, 1, 0, 0};

  initial begin
    n_vec = 0; n_err = 0; n_pulses = 0; edge_k = 0; chk_en = 1'b0;
    bif.element_ready  = 1'b0; bif.element  = '0;
    if12.element_ready = 1'b0; if12.element = '0;
    if14.element_ready = 1'b0; if14.element = '0;
    if31.element_ready = 1'b0; if31.element = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_result", 64'(bif.result), 64'd0);
    check("rst_valid", 64'(bif.result_valid), 64'd0);
    check("rst_busy", 64'(bif.busy), 64'd0);

    // 2*5 + 3*7 with one idle cycle between strobes
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if12.element_ready = 1'b1;
      if12.element       = 8'(s12[i]);
      @(negedge clk);
      if12.element_ready = 1'b0;
      if (i == 0) check("t1_busy_rise", 64'(if12.busy), 64'd1);
      if (i == 3) check("t1_valid_early", 64'(if12.result_valid), 64'd0);
    end
    @(negedge clk);
    check("t1_valid", 64'(if12.result_valid), 64'd1);
    check("t1_result", 64'(if12.result), 64'd31);
    check("t1_busy_fall", 64'(if12.busy), 64'd0);
    @(negedge clk);
    check("t1_valid_once", 64'(if12.result_valid), 64'd0);
    check("t1_result_hold", 64'(if12.result), 64'd31);

    // Full-scale 0xFF elements, no truncation
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if14.element_ready = 1'b1;
      if14.element       = 8'hFF;
    end
    @(negedge clk);
    if14.element_ready = 1'b0;
    check("t2_valid_early", 64'(if14.result_valid), 64'd0);
    @(negedge clk);
    check("t2_valid", 64'(if14.result_valid), 64'd1);
    check("t2_result", 64'(if14.result), 64'h3F804);

    // Back-to-back single-pair vectors
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n > 0) begin
        check("t3_valid", 64'(if31.result_valid), 64'(v31[n-1]));
        check("t3_result", 64'(if31.result), 64'(r31[n-1]));
        check("t3_busy", 64'(if31.busy), 64'(b31[n-1]));
      end
      if (n < 4) begin
        if31.element_ready = 1'b1;
        if31.element       = 24'(s31[n]);
      end else begin
        if31.element_ready = 1'b0;
      end
    end

    // Partial vector discarded by reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bif.element_ready = 1'b1;
      bif.element       = 24'd9;
    end
    @(negedge clk);
    bif.element_ready = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bif.element_ready = 1'b1;
      bif.element       = 24'd1;
    end
    @(negedge clk);
    bif.element_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_result", 64'(bif.result), 64'd3);
    check("t4_model_pin", m_result, 64'd3);

    // Random values and gaps
    n_pulses = 0;
    for (int v = 0; v < 20; v++) begin
      for (int e = 0; e < 2 * VL; e++) begin
        int g;
        @(negedge clk);
        bif.element_ready = 1'b1;
        bif.element       = 24'($urandom);
        g = int'($urandom_range(0, 10));
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          bif.element_ready = 1'b0;
        end
      end
    end
    @(negedge clk);
    bif.element_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_pulse_count", 64'(n_pulses), 64'd20);
    check("t5_busy_idle", 64'(bif.busy), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Consumes the element stream produced by `element_constructor` and computes unsigned dot products of two interleaved vectors. Elements arrive as A0, B0, A1, B1, …; each A/B pair is multiplied in a registered product stage and summed into an accumulator. After `VECTOR_LENGTH` pairs the block emits one result with a single-cycle valid pulse and restarts for the next vector. It sits directly downstream of `element_constructor`, with its `element`/`element_ready` outputs wired straight in.

## Interface
- `ELEMENT_WIDTH`, 3: bytes per element; element is `ELEMENT_WIDTH*8` bits, unsigned.
- `VECTOR_LENGTH`, 3: A/B pairs per dot product; must be ≥1.
- `clk`  input  1  single clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `element`  input  `ELEMENT_WIDTH*8`  element data; sampled only when `element_ready`=1.
- `element_ready`  input  1  one-cycle strobe; may be high on consecutive cycles.
- `result`  output  `RESULT_W`  completed dot product. `RESULT_W = 2*ELEMENT_WIDTH*8 + clog2(VECTOR_LENGTH)`, with `clog2(1)` taken as 0.
- `result_valid`  output  1  high for exactly one cycle per completed vector.
- `busy`  output  1  high from the first accepted A element until the cycle `result_valid` is asserted.

## Operation
- Phase tracking:
  - A 1-bit phase register selects A or B (0 = expecting A, 1 = expecting B).
  - A pair counter runs 0..`VECTOR_LENGTH`-1.
- Input stage. On each `element_ready`:
  - Phase A: latch `element` into `a_reg`, set phase=1.
  - Phase B: register `a_reg*element` (full `2*ELEMENT_WIDTH*8` bits) into `prod`, and set `prod_valid`=1.
  - Phase B also sets `prod_first` when the pair counter is 0 and `prod_last` when the pair counter is `VECTOR_LENGTH`-1.
  - Phase B then sets phase=0 and advances the pair counter, wrapping to 0 after `VECTOR_LENGTH`-1.
- Accumulate stage. When `prod_valid`=1:
  - `acc = prod_first ? prod : acc + prod`.
  - If `prod_last` is also set, load `result` with the same new value and pulse `result_valid`.
- Arithmetic: unsigned throughout. `prod` is zero-extended to `RESULT_W`. `RESULT_W` guarantees no overflow, so no saturation or overflow flag is needed.
- Vector boundaries:
  - The `prod_first` flag makes the accumulator restart without a clear cycle. Back-to-back vectors need no idle gap.
  - `result` holds its value until the next vector completes.
- Gaps between strobes of any length are legal. No timeout applies.
- Reset (`reset`=0, asynchronous), including mid-vector:
  - Clears phase, pair counter, `a_reg`, `prod`, `prod_valid`, `prod_first`, `prod_last`, `acc`, `result`, `result_valid` and `busy`.
  - Any partial vector is discarded. The first strobe after release is treated as A0.
- Reset values: `result`=0, `result_valid`=0, `busy`=0.

## Timing
- `element_ready` for B(VECTOR_LENGTH-1) is sampled at edge t; `prod_valid` is high after edge t; `result`/`result_valid` are valid after edge t+1. Result latency is 2 cycles from the last B strobe.
- Throughput: one element per cycle, sustained indefinitely, across vector boundaries.
- The accumulate stage for vector n's last pair and the input stage for vector n+1's A0 may act on the same edge. The two are independent and both must complete.
- `busy` rises after the edge that accepts A0 and falls after the edge that asserts `result_valid`.
  - If the next vector's A0 is accepted on that same edge, `busy` stays high.
- Reset release is synchronized externally; the block takes no extra action on deassertion.

## Structure
- Shared package `vm_pkg`:
  - `clog2` function.
  - Width macros/localparams for element width (`ELEMENT_WIDTH*8`), product width and `RESULT_W`, shared with `element_constructor` and later stages.
  - Phase encoding constants `PHASE_A`/`PHASE_B`.
- One sub-module is natural: `mac_stage`, holding `prod`→`acc`→`result`/`result_valid`, with inputs `prod`, `prod_valid`, `prod_first`, `prod_last`.
- The top level holds the phase/counter logic and the multiplier register.

## Test plan
- `ELEMENT_WIDTH`=1, `VECTOR_LENGTH`=2, strobes spaced 2 cycles, stream 2,5,3,7 -> `result`=31 (0x1F), `result_valid` one cycle, exactly 2 cycles after the strobe carrying 7.
- `ELEMENT_WIDTH`=1, `VECTOR_LENGTH`=4, eight consecutive strobes of 0xFF -> `result`=0x3F804 (`RESULT_W`=18), no truncation.
- `ELEMENT_WIDTH`=3, `VECTOR_LENGTH`=1, back-to-back vectors with no gap:
  - (0x000002, 0x000003) then (0x000004, 0x000005) -> `result_valid` pulses on two cycles 2 apart, values 6 then 20.
  - `busy` stays continuously high.
- `VECTOR_LENGTH`=3: send A0, B0, A1, then assert `reset`=0 for 1 cycle. Then send 1,1,1,1,1,1 -> the single `result` is 3; no result appears for the aborted vector.
- Random gaps of 0–10 cycles between strobes, 20 vectors of random values -> every `result` matches the scoreboard. `result_valid` count equals the vector count; `busy` is low only between vectors.
- After reset and before any strobe -> `result`=0, `result_valid`=0, `busy`=0.
